vram_write_queue: RTL and testbench

- Buffers CPU writes to VRAM and schedules them onto the single VRAM port; the GPU pixel pipeline uses the same port for fetches.
- Sits between the address decoder / CPU bus (write_enable, SELECT_vram) and the GPU's VRAM storage.
- GPU fetches have fixed, absolute priority, so display timing is never disturbed. CPU writes are queued and drained in cycles the GPU leaves idle.

---
 rtl/vram_write_queue.sv | 155 +++++++++++++++
 tb/tb_vram_write_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_queue.sv
// vram_write_queue
// Buffers CPU writes to VRAM in a small circular queue and drains them onto
// the single VRAM port in cycles the GPU pixel pipeline leaves idle. GPU
// fetches always own the port, so display timing is never disturbed; CPU
// writes wait for a gap, strictly in arrival order, with no forwarding.
module vram_write_queue #(
    parameter int DEPTH  = 8,   // queue entries, power of 2, at least 2
    parameter int ADDR_W = 12,  // VRAM address width
    parameter int DATA_W = 8    // VRAM data width
) (
    input  logic                     clk_12_5875,
    input  logic                     rst,
    // CPU write strobe (already decoded and synchronised)
    input  logic                     cpu_wr_valid,
    input  logic [ADDR_W-1:0]        cpu_wr_addr,
    input  logic [DATA_W-1:0]        cpu_wr_data,
    // GPU fetch side
    input  logic                     gpu_rd_req,
    input  logic [ADDR_W-1:0]        gpu_rd_addr,
    output logic [DATA_W-1:0]        gpu_rd_data,
    output logic                     gpu_rd_valid,
    // Shared VRAM port
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [DATA_W-1:0]        vram_wdata,
    output logic                     vram_we,
    input  logic [DATA_W-1:0]        vram_rdata,
    // Status visible to the CPU
    output logic                     queue_empty,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // Queue storage: one {addr, data} pair per entry. The head is read
    // combinationally because the port must present it in the same cycle
    // the arbiter grants the write slot.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg,  count_next;
    logic              overflow_reg, overflow_next;
    logic              gpu_rd_valid_reg;

    logic              is_full;
    logic              is_empty;
    logic              pop;
    logic              push;
    logic              drop;

    assign is_full  = (count_reg == FULL_CNT);
    assign is_empty = (count_reg == '0);

    // A write slot exists only when the GPU is idle; a pending head entry
    // then goes out and is retired at the edge. A push is accepted when
    // there is room, or when the pop in this same cycle frees a slot.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        if (!gpu_rd_req && !is_empty) begin
            pop = 1'b1;
        end
        if (cpu_wr_valid) begin
            if (!is_full || pop) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + ONE_PTR;
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + ONE_CNT;
            2'b01:   count_next = count_reg - ONE_CNT;
            default: count_next = count_reg;
        endcase

        // A drop in the same cycle as a clear must still be reported.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_overflow) begin
            overflow_next = 1'b0;
        end
    end

    // Control state; reset discards every pending write immediately.
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            overflow_reg     <= 1'b0;
            gpu_rd_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            overflow_reg     <= overflow_next;
            gpu_rd_valid_reg <= gpu_rd_req;
        end
    end

    // Entry write; contents need no reset since count gates their use.
    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head
    // has already been presented this cycle, so overwriting it is safe.
    always_ff @(posedge clk_12_5875) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= cpu_wr_addr;
            data_mem[wr_ptr_reg] <= cpu_wr_data;
        end
    end

    // Port arbitration: the GPU always wins; otherwise drain the head.
    always_comb begin
        vram_addr  = gpu_rd_addr;
        vram_wdata = data_mem[rd_ptr_reg];
        vram_we    = 1'b0;
        if (pop) begin
            vram_addr = addr_mem[rd_ptr_reg];
            vram_we   = 1'b1;
        end
    end

    // Fetch data comes straight from the synchronous VRAM read port.
    assign gpu_rd_data  = vram_rdata;
    assign gpu_rd_valid = gpu_rd_valid_reg;

    assign queue_empty  = is_empty;
    assign queue_count  = count_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_vram_write_queue.sv
// Testbench for vram_write_queue: directed scenarios plus randomized GPU
// bursts and CPU writes. A behavioural model keeps the pending-write list
// and a reference VRAM image; a negedge monitor pops the expected port
// writes from a scoreboard queue whenever the DUT drives vram_we.
module tb_vram_write_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              cpu_wr_valid;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              gpu_rd_req;
    logic [ADDR_W-1:0] gpu_rd_addr;
    logic [DATA_W-1:0] gpu_rd_data;
    logic              gpu_rd_valid;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_wdata;
    logic              vram_we;
    logic [DATA_W-1:0] vram_rdata;
    logic              queue_empty;
    logic [3:0]        queue_count;
    logic              overflow;
    logic              clr_overflow;

    vram_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_12_5875 (clk),
        .rst         (rst),
        .cpu_wr_valid(cpu_wr_valid),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .gpu_rd_req  (gpu_rd_req),
        .gpu_rd_addr (gpu_rd_addr),
        .gpu_rd_data (gpu_rd_data),
        .gpu_rd_valid(gpu_rd_valid),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_we     (vram_we),
        .vram_rdata  (vram_rdata),
        .queue_empty (queue_empty),
        .queue_count (queue_count),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    wr_t         model_q[$];   // accepted, not yet written
    wr_t         exp_q[$];     // scoreboard of expected port writes
    logic [7:0]  ref_mem  [4096];
    logic [7:0]  vram_m   [4096];
    bit          touched  [4096];
    bit          ovf_m;
    bit          prev_req_m;
    logic [7:0]  fetch_exp;
    bit          m_pop;
    bit          m_push;
    wr_t         m_e;
    wr_t         s_e;
    bit          exp_we;

    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: one step per clock edge from the spec's rules.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_q.delete();
                exp_q.delete();
                ovf_m      = 1'b0;
                prev_req_m = 1'b0;
            end else begin
                m_pop  = !gpu_rd_req && (model_q.size() > 0);
                m_push = cpu_wr_valid && ((model_q.size() < DEPTH) || m_pop);
                if (gpu_rd_req) fetch_exp = ref_mem[gpu_rd_addr];
                if (m_pop) begin
                    m_e = model_q.pop_front();
                    ref_mem[m_e.a] = m_e.d;
                end
                if (m_push) begin
                    model_q.push_back({cpu_wr_addr, cpu_wr_data});
                    exp_q.push_back({cpu_wr_addr, cpu_wr_data});
                    touched[cpu_wr_addr] = 1'b1;
                end
                if (cpu_wr_valid && !m_push) ovf_m = 1'b1;
                else if (clr_overflow) ovf_m = 1'b0;
                prev_req_m = gpu_rd_req;
            end
        end
    end

    // Synchronous VRAM read port backed by what the DUT actually wrote.
    initial begin
        forever begin
            @(posedge clk);
            vram_rdata <= vram_m[vram_addr];
        end
    end

    // Monitor: compares the port and status against the model each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_we = !gpu_rd_req && (model_q.size() > 0);
                chk("vram_we", 32'(vram_we), 32'(exp_we));
                if (vram_we) begin
                    vram_m[vram_addr] = vram_wdata;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'(vram_addr), 32'hFFFF_FFFF);
                    end else begin
                        s_e = exp_q.pop_front();
                        chk("wr_addr", 32'(vram_addr), 32'(s_e.a));
                        chk("wr_data", 32'(vram_wdata), 32'(s_e.d));
                    end
                    $display("port write addr=%03h data=%02h count=%0d", vram_addr, vram_wdata, queue_count);
                end
                if (gpu_rd_req) chk("fetch_addr", 32'(vram_addr), 32'(gpu_rd_addr));
                chk("rd_valid", 32'(gpu_rd_valid), 32'(prev_req_m));
                if (gpu_rd_valid) chk("rd_data", 32'(gpu_rd_data), 32'(fetch_exp));
                chk("count", 32'(queue_count), 32'(model_q.size()));
                chk("empty", 32'(queue_empty), 32'(model_q.size() == 0));
                chk("overflow", 32'(overflow), 32'(ovf_m));
            end
        end
    end

    task automatic step(input bit wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input bit req, input logic [ADDR_W-1:0] ra, input bit clr);
        cpu_wr_valid = wr;
        cpu_wr_addr  = wa;
        cpu_wr_data  = wd;
        gpu_rd_req   = req;
        gpu_rd_addr  = ra;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        cpu_wr_valid = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && !queue_empty; k++) idle(1);
        chk(name, 32'(queue_empty), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"},    32'(vram_we),      32'd0);
        chk({tag, "_empty"}, 32'(queue_empty),  32'd1);
        chk({tag, "_count"}, 32'(queue_count),  32'd0);
        chk({tag, "_ovf"},   32'(overflow),     32'd0);
        chk({tag, "_valid"}, 32'(gpu_rd_valid), 32'd0);
    endtask

    int nw;
    int burst_left;
    bit rreq;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = 8'h00;
            vram_m[i]  = 8'h00;
            touched[i] = 1'b0;
        end
        ovf_m        = 1'b0;
        prev_req_m   = 1'b0;
        fetch_exp    = 8'h00;
        vram_rdata   = 8'h00;
        cpu_wr_valid = 1'b0;
        cpu_wr_addr  = '0;
        cpu_wr_data  = '0;
        gpu_rd_req   = 1'b0;
        gpu_rd_addr  = '0;
        clr_overflow = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        idle(3);

        // Three writes with the GPU idle: each drains one cycle later.
        step(1'b1, 12'h010, 8'hAA, 1'b0, '0, 1'b0);
        step(1'b1, 12'h011, 8'hBB, 1'b0, '0, 1'b0);
        step(1'b1, 12'h012, 8'hCC, 1'b0, '0, 1'b0);
        idle(2);
        chk("t1_empty", 32'(queue_empty), 32'd1);
        chk("t1_mem_012", 32'(vram_m[12'h012]), 32'hCC);

        // GPU busy for 20 cycles while 4 writes queue up.
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            if ((i % 3 == 1) && nw < 4) begin
                step(1'b1, 12'(12'h300 + i), 8'($urandom), 1'b1, 12'(12'h500 + i), 1'b0);
                nw++;
            end else begin
                step(1'b0, '0, '0, 1'b1, 12'(12'h500 + i), 1'b0);
            end
        end
        chk("t2_count4", 32'(queue_count), 32'd4);
        idle(4);
        chk("t2_drained", 32'(queue_empty), 32'd1);

        // Nine writes while blocked: the ninth is dropped.
        for (int i = 0; i < 9; i++) step(1'b1, 12'(12'h600 + i), 8'(8'h40 + i), 1'b1, 12'h010, 1'b0);
        chk("t3_full", 32'(queue_count), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd1);
        drain("t3_drain");
        chk("t3_no9th", 32'(vram_m[12'h608]), 32'd0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        chk("t3_clr", 32'(overflow), 32'd0);

        // Full queue, GPU idle, push and pop in the same cycle.
        for (int i = 0; i < 8; i++) step(1'b1, 12'(12'h700 + i), 8'(8'h80 + i), 1'b1, 12'h011, 1'b0);
        step(1'b1, 12'h708, 8'h5A, 1'b0, '0, 1'b0);
        chk("t4_count8", 32'(queue_count), 32'd8);
        chk("t4_no_ovf", 32'(overflow), 32'd0);
        drain("t4_drain");
        chk("t4_mem_708", 32'(vram_m[12'h708]), 32'h5A);

        // Same address written twice: last value wins.
        step(1'b1, 12'h200, 8'h11, 1'b0, '0, 1'b0);
        step(1'b1, 12'h200, 8'h22, 1'b0, '0, 1'b0);
        idle(3);
        chk("t5_last_wins", 32'(vram_m[12'h200]), 32'h22);

        // Randomized writes interleaved with GPU fetch bursts (pointer wrap,
        // hazards on a small address window, occasional overflow/clear).
        burst_left = 0;
        rreq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (burst_left == 0) begin
                rreq = ($urandom_range(0, 1) == 1);
                burst_left = $urandom_range(1, 14);
            end
            burst_left--;
            step(($urandom_range(0, 9) < 4), 12'(12'h100 + $urandom_range(0, 7)), 8'($urandom),
                 rreq, 12'(12'h100 + $urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
        end
        drain("rand_drain");
        chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid-cycle with five writes pending.
        for (int i = 0; i < 5; i++) step(1'b1, 12'(12'h800 + i), 8'(8'hE0 + i), 1'b1, 12'h100, 1'b0);
        #2;
        rst = 1'b1;
        gpu_rd_req = 1'b0;
        #1;
        check_reset("async");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        chk("rst_no_stale", 32'(vram_m[12'h800]), 32'd0);
        chk("rst_empty", 32'(queue_empty), 32'd1);

        // Final VRAM image against the reference built from arrival order.
        for (int i = 0; i < 4096; i++) begin
            if (touched[i]) chk("vram_image", 32'(vram_m[i]), 32'(ref_mem[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
